// File: rtl/reset_sequencer.sv
// Ordered reset release for NUM_STAGES downstream domains. Waits for a
// qualified PLL lock, then drops one stage reset every STAGE_DELAY cycles.
// Loss of lock or a software request re-asserts every stage at once.
//
// state     | meaning
// ----------+------------------------------------------------------------
// HOLD      | upstream reset just released, all stages held
// WAIT_LOCK | counting consecutive synchronized-lock cycles
// RELEASE   | releasing stages in order, one per STAGE_DELAY cycles
// RUN       | all stages released, DONE high
// SW_HOLD   | software reset hold, all stages held for SW_RST_HOLD cycles
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int LOCK_STABLE = 64,
    parameter int STAGE_DELAY = 16,
    parameter int SW_RST_HOLD = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PLL_LOCKED,
    input  logic                  SW_RST,
    output logic [NUM_STAGES-1:0] RST_OUT,
    output logic                  DONE,
    output logic [2:0]            STATE
);

    localparam int STABLE_W = $clog2(LOCK_STABLE + 1);
    localparam int DLY_W    = $clog2(STAGE_DELAY + 1);
    localparam int HOLD_W   = $clog2(SW_RST_HOLD + 1);
    localparam int IDX_W    = $clog2(NUM_STAGES + 1);

    // Each counter compares against limit-1 so the state change lands on the
    // edge where the count would reach its limit; no counter ever wraps.
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [DLY_W-1:0]    DLY_LAST    = DLY_W'(STAGE_DELAY - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(SW_RST_HOLD - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_SW_HOLD   = 3'd4
    } state_t;

    state_t              state;
    logic                lock_s1;
    logic                lock_s;
    logic [STABLE_W-1:0] stable_cnt;
    logic [DLY_W-1:0]    dly_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]    stage_idx;

    assign STATE = state;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_s1 <= PLL_LOCKED;
            lock_s  <= lock_s1;
        end
    end

    // Sequencing FSM; lock loss outranks a software request in every active state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_HOLD;
            RST_OUT    <= '1;
            DONE       <= 1'b0;
            stable_cnt <= '0;
            dly_cnt    <= '0;
            hold_cnt   <= '0;
            stage_idx  <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    state <= S_WAIT_LOCK;
                end

                S_WAIT_LOCK: begin
                    if (!lock_s || SW_RST) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state      <= S_RELEASE;
                        stable_cnt <= '0;
                        stage_idx  <= '0;
                        dly_cnt    <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end

                S_RELEASE, S_RUN, S_SW_HOLD: begin
                    if (!lock_s) begin
                        state      <= S_WAIT_LOCK;
                        RST_OUT    <= '1;
                        DONE       <= 1'b0;
                        stable_cnt <= '0;
                        dly_cnt    <= '0;
                        hold_cnt   <= '0;
                        stage_idx  <= '0;
                    end else if (SW_RST && state != S_SW_HOLD) begin
                        state    <= S_SW_HOLD;
                        RST_OUT  <= '1;
                        DONE     <= 1'b0;
                        hold_cnt <= '0;
                        dly_cnt  <= '0;
                    end else if (state == S_SW_HOLD) begin
                        if (SW_RST) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state     <= S_RELEASE;
                            hold_cnt  <= '0;
                            stage_idx <= '0;
                            dly_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (state == S_RELEASE) begin
                        if (dly_cnt == DLY_LAST) begin
                            // Outputs stay a contiguous run of ones at the top,
                            // so releasing the next stage is a left shift.
                            dly_cnt   <= '0;
                            RST_OUT   <= RST_OUT << 1;
                            stage_idx <= stage_idx + 1'b1;
                            if (stage_idx == IDX_LAST) begin
                                state <= S_RUN;
                                DONE  <= 1'b1;
                            end
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= S_HOLD;
                    RST_OUT <= '1;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus a randomized lock/software
// reset phase, all compared against a time-based model of the release schedule.
module tb_reset_sequencer;

    localparam int NS   = 4;
    localparam int LS   = 64;
    localparam int SD   = 16;
    localparam int SH   = 8;
    localparam int E0   = LS + SD + 2;

    localparam int M_HOLD = 0;
    localparam int M_WAIT = 1;
    localparam int M_REL  = 2;
    localparam int M_RUN  = 3;
    localparam int M_SWH  = 4;

    logic          CLK;
    logic          RST;
    logic          PLL_LOCKED;
    logic          SW_RST;
    logic [NS-1:0] RST_OUT;
    logic          DONE;
    logic [2:0]    STATE;

    int errors = 0;
    int checks = 0;

    // model: mode, qualification run length, edges since release began, hold edges
    int m_st, m_qual, m_seq, m_hold;
    bit m_s1, m_s2;

    reset_sequencer #(
        .NUM_STAGES (NS),
        .LOCK_STABLE(LS),
        .STAGE_DELAY(SD),
        .SW_RST_HOLD(SH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PLL_LOCKED(PLL_LOCKED),
        .SW_RST    (SW_RST),
        .RST_OUT   (RST_OUT),
        .DONE      (DONE),
        .STATE     (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_HOLD; m_qual = 0; m_seq = 0; m_hold = 0;
        m_s1 = 1'b0;   m_s2 = 1'b0;
    endtask

    // One clock edge of the reference: lock is seen two edges late, release
    // progress is measured as elapsed edges since the sequence started.
    task automatic model_edge();
        bit ls;
        if (RST) begin
            model_reset();
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = PLL_LOCKED;
        case (m_st)
            M_HOLD: begin
                m_st = M_WAIT; m_qual = 0;
            end
            M_WAIT: begin
                if (!ls || SW_RST) m_qual = 0;
                else begin
                    m_qual++;
                    if (m_qual == LS) begin m_st = M_REL; m_seq = 0; end
                end
            end
            default: begin
                if (!ls) begin
                    m_st = M_WAIT; m_qual = 0;
                end else if (SW_RST && m_st != M_SWH) begin
                    m_st = M_SWH; m_hold = 0;
                end else if (m_st == M_REL) begin
                    m_seq++;
                    if (m_seq == NS * SD) m_st = M_RUN;
                end else if (m_st == M_SWH) begin
                    if (SW_RST) m_hold = 0;
                    else begin
                        m_hold++;
                        if (m_hold == SH) begin m_st = M_REL; m_seq = 0; end
                    end
                end
            end
        endcase
    endtask

    function automatic logic [NS-1:0] model_rst_out();
        int rel;
        logic [NS-1:0] ones;
        ones = '1;
        rel  = 0;
        if (m_st == M_REL) rel = m_seq / SD;
        else if (m_st == M_RUN) rel = NS;
        return (rel >= NS) ? '0 : (ones << rel);
    endfunction

    task automatic model_compare();
        logic [NS-1:0] inv;
        inv = ~RST_OUT;
        chk("model_rst_out", 32'(RST_OUT), 32'(model_rst_out()));
        chk("model_done",    32'(DONE),    32'(m_st == M_RUN));
        chk("model_state",   32'(STATE),   32'(m_st));
        chk("monotone",      32'((inv & (inv + 1'b1)) == '0), 32'd1);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        model_compare();
    endtask

    // Absolute-timing release schedule, edges counted from the first edge on
    // which qualification can begin.
    function automatic logic [NS-1:0] sched(input int n, input int first);
        logic [NS-1:0] e;
        e = '1;
        for (int k = 0; k < NS; k++)
            if (n >= first + k * SD) e[k] = 1'b0;
        return e;
    endfunction

    task automatic nominal_run(input string tag);
        for (int n = 1; n <= E0 + NS * SD - SD + 5; n++) begin
            step();
            chk(tag, 32'(RST_OUT), 32'(sched(n, E0)));
            if (n == E0 + (NS - 1) * SD) begin
                chk({tag, "_done"},  32'(DONE),  32'd1);
                chk({tag, "_state"}, 32'(STATE), 32'd3);
            end
        end
    endtask

    initial begin
        int g;
        int drop_left;
        model_reset();
        RST = 1'b1; PLL_LOCKED = 1'b1; SW_RST = 1'b0;
        #1;
        chk("reset_rst_out", 32'(RST_OUT), 32'hF);
        chk("reset_done",    32'(DONE),    32'd0);
        chk("reset_state",   32'(STATE),   32'd0);
        repeat (3) step();

        // nominal release from reset
        RST = 1'b0;
        nominal_run("nominal");

        // lock loss in RUN, then relock repeats the full sequence
        PLL_LOCKED = 1'b0;
        repeat (3) step();
        chk("lockloss_rst_out", 32'(RST_OUT), 32'hF);
        chk("lockloss_done",    32'(DONE),    32'd0);
        chk("lockloss_state",   32'(STATE),   32'd1);
        PLL_LOCKED = 1'b1;
        nominal_run("relock");

        // software reset in RUN
        SW_RST = 1'b1;
        step();
        SW_RST = 1'b0;
        chk("swrst_state",   32'(STATE),   32'd4);
        chk("swrst_rst_out", 32'(RST_OUT), 32'hF);
        repeat (SH - 1) step();
        chk("swhold_still",  32'(STATE),   32'd4);
        step();
        chk("swhold_exit",   32'(STATE),   32'd2);
        for (int n = 1; n <= NS * SD; n++) begin
            step();
            chk("sw_release", 32'(RST_OUT), 32'(sched(n, SD)));
        end
        chk("sw_done", 32'(DONE), 32'd1);

        // lock loss and software request seen on the same edge in RELEASE
        SW_RST = 1'b1;
        step();
        SW_RST = 1'b0;
        repeat (SH + 20) step();
        chk("simul_in_release", 32'(STATE), 32'd2);
        PLL_LOCKED = 1'b0;
        repeat (2) step();
        SW_RST = 1'b1;
        step();
        SW_RST = 1'b0;
        PLL_LOCKED = 1'b1;
        chk("simul_state",   32'(STATE),   32'd1);
        chk("simul_rst_out", 32'(RST_OUT), 32'hF);
        chk("simul_done",    32'(DONE),    32'd0);

        // lock glitch during qualification delays the release by its position
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        g = $urandom_range(10, 60);
        for (int n = 1; n <= g + E0 + 2; n++) begin
            PLL_LOCKED = (n == g) ? 1'b0 : 1'b1;
            step();
            if (n == E0)         chk("glitch_no_early",  32'(RST_OUT), 32'hF);
            if (n == g + E0 - 1) chk("glitch_pre_rel",   32'(RST_OUT[0]), 32'd1);
            if (n == g + E0)     chk("glitch_rel",       32'(RST_OUT[0]), 32'd0);
        end
        PLL_LOCKED = 1'b1;

        // async reset between edges after stage 1 has released
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        repeat (E0 + SD + 2) step();
        chk("async_pre", 32'(RST_OUT), 32'hC);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk("async_rst_out", 32'(RST_OUT), 32'hF);
        chk("async_done",    32'(DONE),    32'd0);
        chk("async_state",   32'(STATE),   32'd0);
        repeat (2) step();
        RST = 1'b0;
        nominal_run("after_async");

        // randomized lock drops and software requests
        drop_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (drop_left > 0) begin
                PLL_LOCKED = 1'b0;
                drop_left--;
            end else begin
                PLL_LOCKED = 1'b1;
                if ($urandom_range(0, 149) == 0) drop_left = $urandom_range(1, 4);
            end
            SW_RST = ($urandom_range(0, 99) == 0);
            step();
        end
        SW_RST = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the reset synchronizer.
- Consumes the synchronized domain reset and releases NUM_STAGES ordered reset outputs one at a time, with a fixed spacing between them.
- Waits for a stable PLL lock before starting the release sequence.
- Re-asserts all outputs on loss of lock or on a software reset request.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be >= 1.
- LOCK_STABLE, 64: consecutive synchronized-lock cycles required before sequencing begins; must be >= 1.
- STAGE_DELAY, 16: cycles between successive stage releases, including before stage 0; must be >= 1.
- SW_RST_HOLD, 8: cycles all outputs are held after a software reset request; must be >= 1.

Ports:
- CLK  input  1  domain clock.
- RST  input  1  asynchronous, active-high reset from the upstream synchronizer. Assertion is asynchronous; deassertion arrives synchronous to CLK.
- PLL_LOCKED  input  1  asynchronous lock indicator, synchronized internally.
- SW_RST  input  1  synchronous software reset request, level-sampled each cycle.
- RST_OUT  output  NUM_STAGES  active-high stage resets. Bit 0 releases first.
- DONE  output  1  high when all stages are released and the block is in RUN.
- STATE  output  3  debug encoding: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3, SW_HOLD=4.

Behaviour:
- Single clock domain. All outputs are registered, with no combinational paths from input to output.
- While RST=1, asynchronously:
  - state=HOLD, RST_OUT=all ones, DONE=0.
  - Stable counter, stage index, delay counter and both lock-sync flops are cleared to 0.
- PLL_LOCKED passes through a 2-flop synchronizer; lock_s is the second flop output.
- HOLD: on the first edge with RST=0, go to WAIT_LOCK.
- WAIT_LOCK:
  - The stable counter increments on each edge with lock_s=1 and clears on any edge with lock_s=0.
  - SW_RST=1 clears the stable counter.
  - On the edge where the counter reaches LOCK_STABLE: go to RELEASE, with stage index=0 and delay counter=0.
- RELEASE:
  - The delay counter increments each edge.
  - On the edge it reaches STAGE_DELAY: clear RST_OUT[index], increment index, zero the counter.
  - On the edge releasing index NUM_STAGES-1: go to RUN and set DONE=1 on that same edge.
- RUN: hold outputs unchanged.
- Lock loss:
  - In RELEASE, RUN or SW_HOLD, lock_s=0 on an edge forces RST_OUT=all ones and DONE=0, then goes to WAIT_LOCK with all counters zeroed.
  - Lock loss has priority over SW_RST.
- Software reset:
  - In RELEASE or RUN, SW_RST=1 (with lock_s=1) forces RST_OUT=all ones, DONE=0 and goes to SW_HOLD with the hold counter at 0.
  - SW_HOLD counts edges. SW_RST=1 during SW_HOLD restarts the count at 0.
  - On the edge the count reaches SW_RST_HOLD: go to RELEASE with index=0 and delay=0. Lock qualification is not repeated.
- Timing: with PLL_LOCKED steady high, number edges from edge 1 = first edge with RST=0.
  - RST_OUT[k] falls on edge E0 + k*STAGE_DELAY, where E0 = LOCK_STABLE + STAGE_DELAY + 2.
  - DONE rises on edge E0 + (NUM_STAGES-1)*STAGE_DELAY.
- Output invariants:
  - RST_OUT is monotone during sequencing: a lower index is never asserted while a higher index is deasserted.
  - Every re-assertion sets all bits on a single edge.
- Counter widths are $clog2(max+1) of their respective limits. There is no wrap-around: each counter stops at its limit because the state changes on that edge.
- RST asserted mid-sequence overrides everything immediately (asynchronously), regardless of state.

Test Plan:
- Nominal release. Defaults, PLL_LOCKED=1 before RST falls.
  - Required: RST_OUT goes 1111 -> 1110 at edge 82, 1100 at edge 98, 1000 at edge 114, 0000 at edge 130.
  - DONE=1 at edge 130; STATE=3.
- Lock glitch during qualification. PLL_LOCKED low for 1 cycle after 40 locked cycles.
  - Required: stable counter restarts; RST_OUT[0] release delayed by the glitch position; no early release.
- Lock loss in RUN. Drop PLL_LOCKED after DONE.
  - Required: within 3 edges RST_OUT=1111, DONE=0, STATE=1.
  - On relock, the full E0 sequence repeats.
- Software reset in RUN. SW_RST=1 for 1 cycle.
  - Required: next edge RST_OUT=1111, STATE=4.
  - After 8 edges STATE=2; stages then release at +16, +32, +48, +64.
- Simultaneous events. SW_RST=1 and PLL_LOCKED dropped together in RELEASE.
  - Required: STATE=1 (lock loss wins), not 4.
- Async reset mid-RELEASE. Assert RST between clock edges after stage 1 is released.
  - Required: RST_OUT=1111 and DONE=0 with no clock edge.
  - After RST is released, the full sequence restarts from edge 1.
